// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch stage: pc sequencing, SRAM fetch port, ID instruction capture buffer
// Optional feature: define IF_BR_HOLD_EN to keep a redirect that arrives while IF is stalled.
module inst_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic [32:0] br_bus,
  input  logic [31:0] inst_sram_rdata,
  output logic [32:0] if_to_id_bus,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_wen,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  output logic [31:0] id_inst,
  output logic        id_inst_valid
);

  localparam logic [31:0] PC_RESET = 32'hBFBF_FFFC;
  localparam logic [31:0] PC_START = 32'hBFC0_0000;

  typedef enum logic [1:0] {S_RST, S_FETCH, S_HOLD} state_t;

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx;
  logic        br_e;
  logic [31:0] br_addr;
  logic        buf_valid;
  logic [31:0] buf_data;
  logic        unused_stall;

  assign br_e         = br_bus[32];
  assign br_addr      = br_bus[31:0];
  assign unused_stall = ^stall[5:2];

`ifdef IF_BR_HOLD_EN
  logic        pend_valid, pend_valid_nx;
  logic [31:0] pend_addr, pend_addr_nx;
`endif

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
`ifdef IF_BR_HOLD_EN
    pend_valid_nx = pend_valid;
    pend_addr_nx  = pend_addr;
`endif
    case (state)
      S_RST: begin
        state_nx = S_FETCH;
        pc_nx    = PC_START;
      end
      S_FETCH, S_HOLD: begin
        if (stall[0]) begin
          state_nx = S_HOLD;
`ifdef IF_BR_HOLD_EN
          if (br_e) begin
            pend_valid_nx = 1'b1;
            pend_addr_nx  = br_addr;
          end
`endif
        end else begin
          state_nx = S_FETCH;
          // a live redirect always beats one remembered from the stall
          if (br_e)
            pc_nx = br_addr;
`ifdef IF_BR_HOLD_EN
          else if (pend_valid)
            pc_nx = pend_addr;
`endif
          else
            pc_nx = pc + 32'd4;
`ifdef IF_BR_HOLD_EN
          pend_valid_nx = 1'b0;
`endif
        end
      end
      default: begin
        state_nx = S_RST;
        pc_nx    = PC_RESET;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RST;
      pc    <= PC_RESET;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
    end
  end

`ifdef IF_BR_HOLD_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_addr  <= 32'b0;
    end else begin
      pend_valid <= pend_valid_nx;
      pend_addr  <= pend_addr_nx;
    end
  end
`endif

  // ID keeps the word that was on the SRAM bus when its stall began
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid <= 1'b0;
      buf_data  <= 32'b0;
    end else if (stall[1]) begin
      if (!buf_valid) begin
        buf_valid <= 1'b1;
        buf_data  <= inst_sram_rdata;
      end
    end else begin
      buf_valid <= 1'b0;
    end
  end

  assign inst_sram_en    = (state != S_RST);
  assign inst_sram_addr  = pc;
  assign if_to_id_bus    = {inst_sram_en, pc};
  assign inst_sram_wen   = 4'b0000;
  assign inst_sram_wdata = 32'b0;
  assign id_inst         = buf_valid ? buf_data : inst_sram_rdata;
  assign id_inst_valid   = buf_valid;

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - self-checking bench for inst_fetch: directed scenarios plus randomized run against a reference model
module tb_inst_fetch;

`ifdef IF_BR_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [32:0] br_bus;
  logic [31:0] inst_sram_rdata;
  logic [32:0] if_to_id_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] id_inst;
  logic        id_inst_valid;

  int checks = 0;
  int errors = 0;

  inst_fetch dut (
    .clk(clk), .rst(rst), .stall(stall), .br_bus(br_bus),
    .inst_sram_rdata(inst_sram_rdata), .if_to_id_bus(if_to_id_bus),
    .inst_sram_en(inst_sram_en), .inst_sram_wen(inst_sram_wen),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .id_inst(id_inst), .id_inst_valid(id_inst_valid)
  );

  always #5 clk = ~clk;

  // reference: what the fetch port and ID buffer must show, kept as plain values
  bit          m_known = 1'b0;
  bit          m_ce;
  logic [31:0] m_pc;
  bit          m_pend_v;
  logic [31:0] m_pend;
  bit          m_buf_v;
  logic [31:0] m_buf;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input logic [5:0] s, input logic [32:0] br, input logic [31:0] rd);
    if (r) begin
      m_known = 1'b1;
      m_ce = 1'b0; m_pc = 32'hBFBF_FFFC;
      m_pend_v = 1'b0; m_buf_v = 1'b0; m_buf = 32'b0;
    end else if (m_known) begin
      if (s[1]) begin
        if (!m_buf_v) begin m_buf = rd; m_buf_v = 1'b1; end
      end else m_buf_v = 1'b0;
      if (!m_ce) begin
        m_ce = 1'b1; m_pc = 32'hBFC0_0000;
      end else if (s[0]) begin
        if (HOLD_EN && br[32]) begin m_pend = br[31:0]; m_pend_v = 1'b1; end
      end else begin
        if (br[32]) m_pc = br[31:0];
        else if (HOLD_EN && m_pend_v) m_pc = m_pend;
        else m_pc = m_pc + 32'd4;
        m_pend_v = 1'b0;
      end
    end
  endtask

  // one clock: check registered outputs, apply inputs, check the ID mux, advance the model
  task automatic cycle(input bit r, input logic [5:0] s, input logic [32:0] br, input logic [31:0] rd);
    @(negedge clk);
    if (m_known) begin
      chk("if_to_id_bus", {31'b0, if_to_id_bus}, {31'b0, m_ce, m_pc});
      chk("inst_sram_en", {63'b0, inst_sram_en}, {63'b0, m_ce});
      chk("inst_sram_addr", {32'b0, inst_sram_addr}, {32'b0, m_pc});
      chk("id_inst_valid", {63'b0, id_inst_valid}, {63'b0, m_buf_v});
      chk("inst_sram_wen", {60'b0, inst_sram_wen}, 64'd0);
      chk("inst_sram_wdata", {32'b0, inst_sram_wdata}, 64'd0);
    end
    rst = r; stall = s; br_bus = br; inst_sram_rdata = rd;
    #1;
    if (m_known)
      chk("id_inst", {32'b0, id_inst}, {32'b0, (m_buf_v ? m_buf : rd)});
    model_step(r, s, br, rd);
  endtask

  task automatic after_edge;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 6'b0; br_bus = 33'b0; inst_sram_rdata = 32'b0;

    cycle(1, 6'b0, 33'b0, 32'h0);
    cycle(1, 6'b000011, {1'b1, 32'h1234_5678}, 32'h5555_AAAA);
    after_edge;
    chk("rst_bus", {31'b0, if_to_id_bus}, {31'b0, 1'b0, 32'hBFBF_FFFC});
    chk("rst_en", {63'b0, inst_sram_en}, 64'd0);
    chk("rst_idv", {63'b0, id_inst_valid}, 64'd0);

    // sequential fetch out of reset
    for (int i = 0; i < 5; i++) begin
      cycle(0, 6'b0, 33'b0, 32'h0000_1000 + i);
      after_edge;
      chk("seq_addr", {32'b0, inst_sram_addr}, {32'b0, 32'hBFC0_0000 + 32'(4 * i)});
      chk("seq_en", {63'b0, inst_sram_en}, 64'd1);
    end

    cycle(0, 6'b0, {1'b1, 32'hBFC0_0100}, 32'h0);
    after_edge;
    chk("br_addr", {32'b0, inst_sram_addr}, {32'b0, 32'hBFC0_0100});
    cycle(0, 6'b0, 33'b0, 32'h0);
    after_edge;
    chk("br_next", {32'b0, inst_sram_addr}, {32'b0, 32'hBFC0_0104});

    // ID capture across a 3-cycle stall with changing SRAM data
    cycle(0, 6'b000011, 33'b0, 32'h3C01_1234);
    after_edge;
    chk("cap_inst0", {32'b0, id_inst}, {32'b0, 32'h3C01_1234});
    chk("cap_valid0", {63'b0, id_inst_valid}, 64'd1);
    for (int i = 0; i < 2; i++) begin
      cycle(0, 6'b000011, 33'b0, 32'hFFFF_FFFF);
      after_edge;
      chk("cap_inst", {32'b0, id_inst}, {32'b0, 32'h3C01_1234});
      chk("cap_pc", {32'b0, inst_sram_addr}, {32'b0, 32'hBFC0_0104});
    end
    cycle(0, 6'b0, 33'b0, 32'hFFFF_FFFF);
    after_edge;
    chk("cap_release_v", {63'b0, id_inst_valid}, 64'd0);
    chk("cap_release_pc", {32'b0, inst_sram_addr}, {32'b0, 32'hBFC0_0108});

    // redirect raised only in the first stalled cycle
    cycle(0, 6'b000001, {1'b1, 32'hBFC0_0200}, 32'h0);
    cycle(0, 6'b000001, 33'b0, 32'h0);
    cycle(0, 6'b0, 33'b0, 32'h0);
    after_edge;
    chk("pend_release", {32'b0, inst_sram_addr},
        {32'b0, (HOLD_EN ? 32'hBFC0_0200 : 32'hBFC0_010C)});

    // reset in the middle of a stall with buffer and pending target live
    cycle(0, 6'b000011, {1'b1, 32'hBFC0_0300}, 32'hAAAA_5555);
    cycle(1, 6'b000011, {1'b1, 32'hBFC0_0400}, 32'h0);
    after_edge;
    chk("midrst_en", {63'b0, inst_sram_en}, 64'd0);
    chk("midrst_pc", {32'b0, inst_sram_addr}, {32'b0, 32'hBFBF_FFFC});
    chk("midrst_idv", {63'b0, id_inst_valid}, 64'd0);
    cycle(0, 6'b0, 33'b0, 32'h0);
    after_edge;
    chk("midrst_restart", {32'b0, inst_sram_addr}, {32'b0, 32'hBFC0_0000});

    // wrap-around and unaligned target
    cycle(0, 6'b0, {1'b1, 32'hFFFF_FFFC}, 32'h0);
    cycle(0, 6'b0, 33'b0, 32'h0);
    after_edge;
    chk("wrap", {32'b0, inst_sram_addr}, 64'd0);
    cycle(0, 6'b0, {1'b1, 32'h0000_0013}, 32'h0);
    cycle(0, 6'b0, 33'b0, 32'h0);
    after_edge;
    chk("unaligned", {32'b0, inst_sram_addr}, {32'b0, 32'h0000_0017});

    // randomized run, checked every cycle against the model
    for (int i = 0; i < 3000; i++) begin
      bit          r;
      logic [5:0]  s;
      logic [32:0] br;
      logic [31:0] tgt;
      r = ($urandom_range(0, 99) < 2);
      s = 6'($urandom);
      s[0] = ($urandom_range(0, 99) < 30);
      s[1] = ($urandom_range(0, 99) < 30);
      case ($urandom_range(0, 3))
        0: tgt = 32'hFFFF_FFFC;
        1: tgt = 32'hFFFF_FFF8;
        default: tgt = $urandom;
      endcase
      br = {($urandom_range(0, 99) < 15), tgt};
      cycle(r, s, br, $urandom);
    end
    cycle(0, 6'b0, 33'b0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
